nco_wave_gen: RTL and testbench

//   Sample source for the PWM audio DAC. Holds a phase accumulator (NCO) that advances

---
 rtl/nco_wave_gen.sv | 199 +++++++++++++++++++
 tb/tb_nco_wave_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nco_wave_gen.sv
// ---------------------------------------------------------------------------
// nco_wave_gen
//   Sample source for the PWM audio DAC. A phase accumulator advances by the
//   frequency control word (fcw) on every dac next_sample pulse while running,
//   and the top CODE_WIDTH bits of the new phase are shaped into a square,
//   sawtooth or triangle code. Pitch, waveform and run/pause are driven by
//   one-cycle debounced button pulses.
//
// Ports
//   clk          in   1            system clock
//   rst_n        in   1            asynchronous active-low reset
//   next_sample  in   1            one-cycle pulse from dac: advance one sample
//   buttons      in   4            one-cycle presses: [0] up, [1] down,
//                                  [2] wave, [3] run/pause
//   code         out  CODE_WIDTH   sample code to dac (registered)
//   fcw          out  PHASE_WIDTH  current frequency control word (registered)
//   wave_sel     out  2            0 square, 1 saw, 2 triangle (registered)
//   running      out  1            1 = accumulator advancing (registered)
// ---------------------------------------------------------------------------
module nco_wave_gen #(
   parameter int unsigned             CODE_WIDTH  = 10,
   parameter int unsigned             PHASE_WIDTH = 24,
   parameter logic [PHASE_WIDTH-1:0]  FCW_INIT    = 24'd75591,
   parameter logic [PHASE_WIDTH-1:0]  FCW_STEP    = 24'd1024,
   parameter logic [PHASE_WIDTH-1:0]  FCW_MIN     = 24'd1024,
   parameter logic [PHASE_WIDTH-1:0]  FCW_MAX     = 24'd4194304,
   parameter logic [CODE_WIDTH-1:0]   SQ_AMP      = 10'd255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   next_sample,
   input  logic [3:0]             buttons,
   output logic [CODE_WIDTH-1:0]  code,
   output logic [PHASE_WIDTH-1:0] fcw,
   output logic [1:0]             wave_sel,
   output logic                   running
);

   localparam int unsigned EXT_WIDTH = PHASE_WIDTH + 1;

   localparam logic [CODE_WIDTH-1:0] MID   = {1'b1, {(CODE_WIDTH-1){1'b0}}};
   localparam logic [CODE_WIDTH-1:0] SQ_HI = MID + SQ_AMP;
   localparam logic [CODE_WIDTH-1:0] SQ_LO = MID - SQ_AMP;

   typedef enum logic [1:0] {
      WAVE_SQUARE = 2'd0,
      WAVE_SAW    = 2'd1,
      WAVE_TRI    = 2'd2
   } wave_e;

   typedef enum logic {
      RUN_PAUSE = 1'b0,
      RUN_RUN   = 1'b1
   } run_e;

   // Button decode
   logic btn_up;
   logic btn_down;
   logic btn_wave;
   logic btn_run;

   assign btn_up   = buttons[0];
   assign btn_down = buttons[1];
   assign btn_wave = buttons[2];
   assign btn_run  = buttons[3];

   wave_e wave_q;
   wave_e wave_d;
   run_e  run_q;
   run_e  run_d;

   logic [PHASE_WIDTH-1:0] acc_q;
   logic [PHASE_WIDTH-1:0] acc_d;
   logic [PHASE_WIDTH-1:0] fcw_q;
   logic [PHASE_WIDTH-1:0] fcw_d;
   logic [CODE_WIDTH-1:0]  code_q;
   logic [CODE_WIDTH-1:0]  code_d;

   // Waveform FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wave_q <= WAVE_SQUARE;
      end else begin
         wave_q <= wave_d;
      end
   end

   // Waveform FSM next state; the unused encoding falls back to square
   always_comb begin
      wave_d = wave_q;
      case (wave_q)
         WAVE_SQUARE: if (btn_wave) wave_d = WAVE_SAW;
         WAVE_SAW:    if (btn_wave) wave_d = WAVE_TRI;
         WAVE_TRI:    if (btn_wave) wave_d = WAVE_SQUARE;
         default:     wave_d = WAVE_SQUARE;
      endcase
   end

   // Run/pause FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= RUN_RUN;
      end else begin
         run_q <= run_d;
      end
   end

   // Run/pause FSM next state
   always_comb begin
      run_d = run_q;
      case (run_q)
         RUN_RUN:   if (btn_run) run_d = RUN_PAUSE;
         RUN_PAUSE: if (btn_run) run_d = RUN_RUN;
         default:   run_d = RUN_RUN;
      endcase
   end

   // FCW update: one bit of headroom so neither the sum nor the difference wraps
   logic [EXT_WIDTH-1:0]   fcw_up_sum;
   logic [EXT_WIDTH-1:0]   fcw_dn_diff;
   logic [PHASE_WIDTH-1:0] fcw_up_val;
   logic [PHASE_WIDTH-1:0] fcw_dn_val;

   always_comb begin
      fcw_up_sum  = {1'b0, fcw_q} + {1'b0, FCW_STEP};
      fcw_dn_diff = {1'b0, fcw_q} - {1'b0, FCW_STEP};

      if (fcw_up_sum > {1'b0, FCW_MAX}) begin
         fcw_up_val = FCW_MAX;
      end else begin
         fcw_up_val = fcw_up_sum[PHASE_WIDTH-1:0];
      end

      // MSB set means the subtraction went negative
      if (fcw_dn_diff[PHASE_WIDTH] || (fcw_dn_diff < {1'b0, FCW_MIN})) begin
         fcw_dn_val = FCW_MIN;
      end else begin
         fcw_dn_val = fcw_dn_diff[PHASE_WIDTH-1:0];
      end

      fcw_d = fcw_q;
      case ({btn_down, btn_up})
         2'b01:   fcw_d = fcw_up_val;
         2'b10:   fcw_d = fcw_dn_val;
         default: fcw_d = fcw_q;
      endcase
   end

   // Phase advance and wave shaping from the post-advance phase
   logic [PHASE_WIDTH-1:0] acc_nxt;
   logic [CODE_WIDTH-1:0]  phase;
   logic [CODE_WIDTH-1:0]  shaped;

   always_comb begin
      acc_nxt = acc_q + fcw_q;
      phase   = acc_nxt[PHASE_WIDTH-1 -: CODE_WIDTH];

      shaped = MID;
      case (wave_q)
         WAVE_SQUARE: shaped = phase[CODE_WIDTH-1] ? SQ_HI : SQ_LO;
         WAVE_SAW:    shaped = phase;
         // Fold the upper half down so the ramp peaks at the half-way phase
         WAVE_TRI:    shaped = phase[CODE_WIDTH-1] ? {~phase[CODE_WIDTH-2:0], 1'b0}
                                                   : { phase[CODE_WIDTH-2:0], 1'b0};
         default:     shaped = MID;
      endcase
   end

   // Next accumulator and code; pause freezes phase and parks code at mid-scale
   always_comb begin
      acc_d  = acc_q;
      code_d = code_q;
      if (run_q == RUN_PAUSE) begin
         code_d = MID;
      end else if (next_sample) begin
         acc_d  = acc_nxt;
         code_d = shaped;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         fcw_q  <= FCW_INIT;
         code_q <= MID;
      end else begin
         acc_q  <= acc_d;
         fcw_q  <= fcw_d;
         code_q <= code_d;
      end
   end

   assign code     = code_q;
   assign fcw      = fcw_q;
   assign wave_sel = wave_q;
   assign running  = (run_q == RUN_RUN);

endmodule

// File: tb/tb_nco_wave_gen.sv
// ---------------------------------------------------------------------------
// tb_nco_wave_gen
//   Directed stimulus for nco_wave_gen. Each next_sample pulse queues its
//   hand-computed code; a monitor pops and compares one clock after the pulse.
//   Control outputs (fcw, wave_sel, running) are checked inline.
// ---------------------------------------------------------------------------
module tb_nco_wave_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        next_sample = 1'b0;
   logic [3:0]  buttons = 4'b0000;
   logic [9:0]  code;
   logic [23:0] fcw;
   logic [1:0]  wave_sel;
   logic        running;

   int n_cmp = 0;
   int n_err = 0;
   int exp_q[$];
   int mon_exp;

   localparam logic [3:0] B_NONE = 4'b0000;
   localparam logic [3:0] B_UP   = 4'b0001;
   localparam logic [3:0] B_DOWN = 4'b0010;
   localparam logic [3:0] B_WAVE = 4'b0100;
   localparam logic [3:0] B_RUN  = 4'b1000;

   nco_wave_gen dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .next_sample (next_sample),
      .buttons     (buttons),
      .code        (code),
      .fcw         (fcw),
      .wave_sel    (wave_sel),
      .running     (running)
   );

   always #5 clk = ~clk;

   // Code monitor: every accepted next_sample edge owes one queued code
   initial begin
      forever begin
         @(posedge clk);
         if (rst_n && next_sample) begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL code_sample: got %0d, no expected code queued", code);
            end else begin
               mon_exp = exp_q.pop_front();
               if (int'(code) != mon_exp) begin
                  n_err++;
                  $display("FAIL code_sample: got %0d, required %0d", code, mon_exp);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] b, input logic s);
      buttons     = b;
      next_sample = s;
      @(posedge clk);
      #1;
      buttons     = B_NONE;
      next_sample = 1'b0;
   endtask

   task automatic press(input logic [3:0] b, input int n);
      for (int i = 0; i < n; i++) step(b, 1'b0);
   endtask

   task automatic sample(input int exp_code);
      exp_q.push_back(exp_code);
      step(B_NONE, 1'b1);
      step(B_NONE, 1'b0);
   endtask

   initial begin
      // Reset values while reset is held
      repeat (2) @(posedge clk);
      #1;
      chk("reset_code", int'(code), 512);
      chk("reset_fcw", int'(fcw), 75591);
      chk("reset_wave", int'(wave_sel), 0);
      chk("reset_running", int'(running), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Sawtooth with fcw = 2^14 from acc = 0
      step(B_WAVE, 1'b0);
      chk("wave_to_saw", int'(wave_sel), 1);
      press(B_DOWN, 80);
      chk("fcw_floor_from_init", int'(fcw), 1024);
      press(B_UP, 15);
      chk("fcw_2p14", int'(fcw), 16384);
      sample(1);
      sample(2);
      sample(3);
      sample(4);

      // Clamp at the ceiling
      press(B_UP, 4100);
      chk("fcw_ceiling", int'(fcw), 4194304);
      step(B_UP, 1'b0);
      chk("fcw_ceiling_hold", int'(fcw), 4194304);

      // Wave FSM wraps back to square; square codes with acc starting at 65536
      step(B_WAVE, 1'b0);
      chk("wave_to_tri", int'(wave_sel), 2);
      step(B_WAVE, 1'b0);
      chk("wave_to_square", int'(wave_sel), 0);
      sample(257);
      sample(767);
      sample(767);
      sample(257);

      // Clamp at the floor
      press(B_DOWN, 4200);
      chk("fcw_floor", int'(fcw), 1024);

      // Up and down together leave fcw alone
      step(B_WAVE, 1'b0);
      chk("wave_to_saw_2", int'(wave_sel), 1);
      press(B_UP, 3);
      chk("fcw_4096", int'(fcw), 4096);
      step(B_UP | B_DOWN, 1'b0);
      chk("fcw_up_down_same_cycle", int'(fcw), 4096);
      press(B_UP, 11);
      chk("fcw_15360", int'(fcw), 15360);

      // Up coincident with next_sample: phase uses 15360, then 16384 applies
      exp_q.push_back(4);
      step(B_UP, 1'b1);
      step(B_NONE, 1'b0);
      chk("fcw_after_collision", int'(fcw), 16384);
      sample(5);

      // Pause: code parks at 512, samples ignored, fcw still adjustable
      step(B_RUN, 1'b0);
      chk("paused_running", int'(running), 0);
      step(B_NONE, 1'b0);
      chk("paused_code", int'(code), 512);
      for (int i = 0; i < 10; i++) sample(512);
      step(B_UP, 1'b0);
      chk("fcw_update_in_pause", int'(fcw), 17408);
      step(B_RUN, 1'b0);
      chk("resumed_running", int'(running), 1);
      chk("resumed_code_before_sample", int'(code), 512);
      sample(7);

      // Wave change only shows on the next sample
      step(B_WAVE, 1'b0);
      chk("wave_to_tri_2", int'(wave_sel), 2);
      chk("code_hold_after_wave_change", int'(code), 7);
      sample(16);
      press(B_UP, 4100);
      chk("fcw_ceiling_2", int'(fcw), 4194304);
      sample(528);
      sample(1006);

      // Asynchronous reset mid-run, checked before any clock edge
      repeat (2) step(B_NONE, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_code", int'(code), 512);
      chk("midrun_reset_fcw", int'(fcw), 75591);
      chk("midrun_reset_wave", int'(wave_sel), 0);
      chk("midrun_reset_running", int'(running), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      sample(257);

      repeat (3) step(B_NONE, 1'b0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
